// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the MIPS core.
//
// Owns the program counter and fetches one instruction at a time from
// instruction memory over a request/valid handshake. The fetched word is held
// for the decoder/datapath until the consumer signals completion, at which
// point the next PC is chosen (jump, taken branch or sequential).
//
// Configuration macro:
//   IF_STAGE_RETIRE_CNT_EN  defined   -> retire_cnt counts completed instrs
//                           undefined -> retire_cnt is constant 0, no register
//
// Ports:
//   clk          in   1  clock, rising edge
//   rstn         in   1  asynchronous active-low reset
//   imem_req     out  1  one-cycle fetch request
//   imem_addr    out 32  fetch address (current pc)
//   imem_rvalid  in   1  fetch data valid
//   imem_rdata   in  32  fetched instruction word
//   instr        out 32  held instruction
//   instr_pc     out 32  address of the held instruction
//   instr_valid  out  1  held instruction is valid and stable
//   instr_ready  in   1  consumer completed instr this cycle
//   pc_sel       in   2  decoder PC_sel (2'b01 = branch)
//   is_jump      in   2  decoder IsJump (2'b01 = j)
//   br_cond      in   1  branch condition true
//   retire_cnt   out 32  completed instruction count
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  pc_sel,
  input  logic [1:0]  is_jump,
  input  logic        br_cond,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;

  logic [31:0] pc4_s;
  logic [31:0] br_off_s;
  logic [31:0] npc_s;

  // Next-PC selection from the held instruction; jump has priority over branch,
  // and any reserved encoding falls through to sequential.
  always_comb begin
    pc4_s    = instr_pc_q + 32'd4;
    br_off_s = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    npc_s    = pc4_s;
    if (is_jump == 2'b01) begin
      npc_s = {pc4_s[31:28], instr_q[25:0], 2'b00};
    end else if ((pc_sel == 2'b01) && br_cond) begin
      npc_s = pc4_s + br_off_s;
    end else begin
      npc_s = pc4_s;
    end
  end

  // Fetch FSM next-state and datapath register updates.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    case (state_q)
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = npc_s;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_FETCH;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  // The FSM resets into FETCH, so the request is qualified with rstn to keep
  // it low while reset is asserted and high in the first cycle after release.
  assign imem_req    = rstn & (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

`ifdef IF_STAGE_RETIRE_CNT_EN
  logic [31:0] retire_q;
  logic        retire_fire_s;

  assign retire_fire_s = (state_q == S_HOLD) & instr_ready;

  // Completed-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_q <= 32'd0;
    end else if (retire_fire_s) begin
      retire_q <= retire_q + 32'd1;
    end else begin
      retire_q <= retire_q;
    end
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule
